// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the 5-stage RISC-V pipeline: load-use and branch
// hazards, E-stage forwarding, multi-cycle multiply sequencing, and perf counters.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MulE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // cnt only has to hold MUL_LAT-2; keep at least one bit for short latencies
  localparam int                CW        = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CW-1:0]     CNT_INIT  = CW'((MUL_LAT > 2) ? (MUL_LAT - 2) : 0);
  localparam logic              MUL_STALL = (MUL_LAT > 1) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             ms_s;
  logic             lw_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Multiply FSM state and remaining-stall counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Multiply FSM next state and multiply-stall request
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ms_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (MulE && MUL_STALL) begin
          ms_s        = 1'b1;
          state_nxt_s = BUSY;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // cnt==0 is the multiply's final E cycle: release the pipeline
        if (cnt_r != {CW{1'b0}}) begin
          ms_s      = 1'b1;
          cnt_nxt_s = cnt_r - CW'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Operand forwarding into E (M beats W) and load-use detection
  always_comb begin
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end else begin
      ForwardAE = 2'b00;
    end
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end else begin
      ForwardBE = 2'b00;
    end
    lw_s = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Stall/flush arbitration: frozen pipeline, then branch squash, then load bubble
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (ms_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
  end

  assign MulBusy = (state_r == BUSY);

  // Saturating performance counters
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (StallF && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (FlushE && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign StallCnt = stall_cnt_r;
  assign FlushCnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a default instance (MUL_LAT=3, CNT_W=16) and a
// MUL_LAT=1 / CNT_W=4 instance share the stimulus; each expectation names its instance.
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MulE;

  logic       sf_a, sd_a, se_a, fd_a, fe_a, fm_a, mb_a;
  logic [1:0] fa_a, fb_a;
  logic [15:0] sc_a, fc_a;
  logic       sf_b, sd_b, se_b, fd_b, fe_b, fm_b, mb_b;
  logic [1:0] fa_b, fb_b;
  logic [3:0] sc_b, fc_b;

  always #5 Clk = ~Clk;

  hazard_ctrl u_a (
    .Clk(Clk), .Rst(Rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulE(MulE),
    .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .FlushD(fd_a), .FlushE(fe_a),
    .FlushM(fm_a), .ForwardAE(fa_a), .ForwardBE(fb_a), .MulBusy(mb_a),
    .StallCnt(sc_a), .FlushCnt(fc_a)
  );

  hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) u_b (
    .Clk(Clk), .Rst(Rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulE(MulE),
    .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .FlushD(fd_b), .FlushE(fe_b),
    .FlushM(fm_b), .ForwardAE(fa_b), .ForwardBE(fb_b), .MulBusy(mb_b),
    .StallCnt(sc_b), .FlushCnt(fc_b)
  );

  // Packed view: {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy,ForwardAE,ForwardBE}
  logic [10:0] o_a, o_b;
  assign o_a = {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, mb_a, fa_a, fb_a};
  assign o_b = {sf_b, sd_b, se_b, fd_b, fe_b, fm_b, mb_b, fa_b, fb_b};

  localparam logic [10:0] O_NONE = 11'b0000000_0000;
  localparam logic [10:0] O_LU   = 11'b1100100_0000;
  localparam logic [10:0] O_BR   = 11'b0001100_0000;
  localparam logic [10:0] O_MS0  = 11'b1110010_0000;
  localparam logic [10:0] O_MS1  = 11'b1110011_0000;
  localparam logic [10:0] O_MB   = 11'b0000001_0000;

  typedef struct {
    string       tag;
    int          dut;
    logic [10:0] o;
    int          scnt;
    int          fcnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: pops every expectation queued for the current cycle and compares
  always @(negedge Clk) begin
    exp_t        e;
    logic [10:0] ao;
    int          as_v, af_v;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        ao = o_a; as_v = int'(sc_a); af_v = int'(fc_a);
      end else begin
        ao = o_b; as_v = int'(sc_b); af_v = int'(fc_b);
      end
      n_cmp++;
      if (ao !== e.o) begin
        n_bad++;
        $display("FAIL %s outputs(dut%0d): got %b expected %b", e.tag, e.dut, ao, e.o);
      end
      n_cmp++;
      if (as_v != e.scnt) begin
        n_bad++;
        $display("FAIL %s StallCnt(dut%0d): got %0d expected %0d", e.tag, e.dut, as_v, e.scnt);
      end
      n_cmp++;
      if (af_v != e.fcnt) begin
        n_bad++;
        $display("FAIL %s FlushCnt(dut%0d): got %0d expected %0d", e.tag, e.dut, af_v, e.fcnt);
      end
    end
  end

  task automatic clr();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0; MulE = 1'b0;
  endtask

  task automatic push_exp(input string tag, input int dut, input logic [10:0] o,
                          input int s, input int f);
    exp_t e;
    e.tag = tag; e.dut = dut; e.o = o; e.scnt = s; e.fcnt = f;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    clr();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;

    clr(); push_exp("reset", 0, O_NONE, 0, 0); push_exp("reset_b", 1, O_NONE, 0, 0); tick();

    clr(); RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    push_exp("fwdA_M", 0, 11'b0000000_1000, 0, 0); tick();
    clr(); RdM = 5'd5; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    push_exp("fwdA_W", 0, 11'b0000000_0100, 0, 0); tick();
    clr(); RegWriteM = 1'b1; RegWriteW = 1'b1;
    push_exp("fwd_x0", 0, O_NONE, 0, 0); tick();
    clr(); Rs1E = 5'd3; Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
    push_exp("fwdB_M", 0, 11'b0000000_0110, 0, 0); tick();

    clr(); LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    push_exp("loaduse", 0, O_LU, 0, 0); tick();
    clr(); push_exp("loaduse_after", 0, O_NONE, 1, 1); tick();
    clr(); LoadE = 1'b1;
    push_exp("loaduse_x0", 0, O_NONE, 1, 1); tick();
    clr(); LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    push_exp("branch_vs_load", 0, O_BR, 1, 1); tick();
    clr(); push_exp("branch_after", 0, O_NONE, 1, 2); tick();

    // Multiply held in E: two stall cycles, then the release cycle
    clr(); MulE = 1'b1; push_exp("mul1_c0", 0, O_MS0, 1, 2); tick();
    clr(); MulE = 1'b1; push_exp("mul1_c1", 0, O_MS1, 2, 2); tick();
    clr(); MulE = 1'b1; push_exp("mul1_c2", 0, O_MB, 3, 2); tick();
    clr(); MulE = 1'b1; push_exp("mul2_c0", 0, O_MS0, 3, 2); tick();
    clr(); MulE = 1'b1; PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    push_exp("mul2_c1_br_lu", 0, O_MS1, 4, 2); tick();
    clr(); MulE = 1'b1; push_exp("mul2_c2", 0, O_MB, 5, 2); tick();
    clr(); MulE = 1'b1; push_exp("mul3_c0", 0, O_MS0, 5, 2); tick();
    clr(); MulE = 1'b1; Rst = 1'b1; push_exp("mul3_c1_rst", 0, O_MS1, 6, 2); tick();
    Rst = 1'b0;
    clr(); push_exp("rst_in_busy", 0, O_NONE, 0, 0); push_exp("rst_b", 1, O_NONE, 0, 0); tick();

    // MUL_LAT=1 instance never stalls on a multiply
    clr(); MulE = 1'b1; push_exp("lat1_c0", 1, O_NONE, 0, 0); tick();
    clr(); MulE = 1'b1; push_exp("lat1_c1", 1, O_NONE, 0, 0); tick();

    // CNT_W=4 instance: held load-use stall saturates both counters at 15
    for (int k = 0; k < 20; k++) begin
      clr(); LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
      push_exp($sformatf("sat_%0d", k), 1, O_LU, (k < 15) ? k : 15, (k < 15) ? k : 15);
      tick();
    end
    clr(); push_exp("sat_hold", 1, O_NONE, 15, 15); tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
